// File: rtl/pwm_config_mc.sv
// pwm_config_mc: Avalon-MM configuration/status slave for N PWM audio player channels
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   avs_s0_write/read        bus strobes; avs_s0_address = {channel, reg[2:0]}
//   avs_s0_writedata         32-bit write data
//   avs_s0_readdata/valid    registered read data, one-cycle valid strobe
//   startaddr/stopaddr       packed per-channel sample address window
//   volume                   packed per-channel volume
//   start/stop               one-cycle per-channel control pulses
//   done                     per-channel playback-finished pulse
//   avm_s0_irq               registered level IRQ of pending & irq_en
module pwm_config_mc #(
   parameter int CHANNELS = 2,
   parameter int AW = 32,
   parameter int VOL_W = 4,
   localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int ADDR_W = CH_BITS + 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      avs_s0_write,
   input  logic                      avs_s0_read,
   input  logic [ADDR_W-1:0]         avs_s0_address,
   input  logic [31:0]               avs_s0_writedata,
   output logic [31:0]               avs_s0_readdata,
   output logic                      avs_s0_readdatavalid,
   output logic [CHANNELS*AW-1:0]    startaddr,
   output logic [CHANNELS*AW-1:0]    stopaddr,
   output logic [CHANNELS*VOL_W-1:0] volume,
   output logic [CHANNELS-1:0]       start,
   output logic [CHANNELS-1:0]       stop,
   input  logic [CHANNELS-1:0]       done,
   output logic                      avm_s0_irq
);
   logic [CH_BITS-1:0]        ch;
   logic [2:0]                rg;
   logic [CHANNELS*AW-1:0]    sa_q, sa_d, so_q, so_d;
   logic [CHANNELS*VOL_W-1:0] vol_q, vol_d;
   logic [CHANNELS-1:0]       irqen_q, irqen_d, busy_q, busy_d, pend_q, pend_d, err_q, err_d;
   logic [CHANNELS-1:0]       start_q, start_d, stop_q, stop_d;
   logic [31:0]               rdata_q, rdata_d, rsel;
   logic                      rvalid_q, irq_q, irq_d;

   assign ch = avs_s0_address[ADDR_W-1:3];
   assign rg = avs_s0_address[2:0];

   // Channel indices beyond CHANNELS never match a generate slot, so such writes fall away.
   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic wsel, go, go_ok, halt_ok, clr_p, clr_e;
      assign wsel    = avs_s0_write & (ch == CH_BITS'(c));
      assign go      = wsel & (rg == 3'd4);
      assign go_ok   = go & ~busy_q[c] & (sa_q[c*AW +: AW] < so_q[c*AW +: AW]);
      assign halt_ok = wsel & (rg == 3'd5) & busy_q[c];
      assign clr_p   = wsel & (rg == 3'd0) & avs_s0_writedata[0];
      assign clr_e   = wsel & (rg == 3'd0) & avs_s0_writedata[2];
      assign start_d[c] = go_ok;
      assign stop_d[c]  = halt_ok;
      // A fresh start outranks a done arriving on the same edge; HALT and done both end playback.
      assign busy_d[c]  = go_ok | (busy_q[c] & ~halt_ok & ~done[c]);
      // Sticky flags: setting events beat clearing writes on the same edge.
      assign pend_d[c]  = done[c] | (pend_q[c] & ~clr_p);
      assign err_d[c]   = (go & ~go_ok) | (err_q[c] & ~clr_e);
      assign sa_d[c*AW +: AW]       = (wsel && rg == 3'd1) ? AW'(avs_s0_writedata) : sa_q[c*AW +: AW];
      assign so_d[c*AW +: AW]       = (wsel && rg == 3'd2) ? AW'(avs_s0_writedata) : so_q[c*AW +: AW];
      assign vol_d[c*VOL_W +: VOL_W] = (wsel && rg == 3'd3) ? VOL_W'(avs_s0_writedata) : vol_q[c*VOL_W +: VOL_W];
      assign irqen_d[c] = (wsel && rg == 3'd6) ? avs_s0_writedata[0] : irqen_q[c];
   end

   always_comb begin
      rsel = '0;
      for (int c = 0; c < CHANNELS; c++)
         if (ch == CH_BITS'(c))
            rsel = rg == 3'd0 ? {29'b0, err_q[c], busy_q[c], pend_q[c]} :
                   rg == 3'd1 ? 32'(sa_q[c*AW +: AW]) :
                   rg == 3'd2 ? 32'(so_q[c*AW +: AW]) :
                   rg == 3'd3 ? 32'(vol_q[c*VOL_W +: VOL_W]) :
                   rg == 3'd6 ? {31'b0, irqen_q[c]} :
                   rg == 3'd7 ? 32'(pend_q) : 32'b0;
      rdata_d = avs_s0_read ? rsel : rdata_q;
      irq_d   = |(pend_q & irqen_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         sa_q     <= '0;
         so_q     <= '0;
         vol_q    <= '0;
         irqen_q  <= '0;
         busy_q   <= '0;
         pend_q   <= '0;
         err_q    <= '0;
         start_q  <= '0;
         stop_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         sa_q     <= sa_d;
         so_q     <= so_d;
         vol_q    <= vol_d;
         irqen_q  <= irqen_d;
         busy_q   <= busy_d;
         pend_q   <= pend_d;
         err_q    <= err_d;
         start_q  <= start_d;
         stop_q   <= stop_d;
         rdata_q  <= rdata_d;
         rvalid_q <= avs_s0_read;
         irq_q    <= irq_d;
      end
   end

   assign avs_s0_readdata      = rdata_q;
   assign avs_s0_readdatavalid = rvalid_q;
   assign startaddr            = sa_q;
   assign stopaddr             = so_q;
   assign volume               = vol_q;
   assign start                = start_q;
   assign stop                 = stop_q;
   assign avm_s0_irq           = irq_q;
endmodule

// File: tb/tb_pwm_config_mc.sv
// tb_pwm_config_mc: directed scenarios plus random traffic checked against a behavioural model
module tb_pwm_config_mc;
   localparam int CH = 2;
   logic        clk = 0, rst = 0, wr = 0, rd = 0;
   logic [3:0]  addr = 0;
   logic [31:0] wd = 0, rdata;
   logic        rvalid, irq;
   logic [63:0] sa, so;
   logic [7:0]  vol;
   logic [1:0]  st, sp, dn = 0;

   always #5 clk = ~clk;

   pwm_config_mc dut (
      .clk(clk), .rst(rst), .avs_s0_write(wr), .avs_s0_read(rd), .avs_s0_address(addr),
      .avs_s0_writedata(wd), .avs_s0_readdata(rdata), .avs_s0_readdatavalid(rvalid),
      .startaddr(sa), .stopaddr(so), .volume(vol), .start(st), .stop(sp), .done(dn),
      .avm_s0_irq(irq)
   );

   logic [31:0] m_sa[CH], m_so[CH];
   logic [3:0]  m_vol[CH];
   bit          m_en[CH], m_busy[CH], m_pend[CH], m_err[CH];
   logic [31:0] e_rd = 0;
   bit          e_rv = 0, e_irq = 0;
   logic [1:0]  e_st = 0, e_sp = 0;
   int          n_cmp = 0, n_bad = 0;
   bit          chk = 0;

   task automatic check(string n, logic [63:0] a, logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   function automatic logic [31:0] m_read(logic [3:0] a);
      int c = int'(a[3]);
      case (a[2:0])
         3'd0: return {29'b0, m_err[c], m_busy[c], m_pend[c]};
         3'd1: return m_sa[c];
         3'd2: return m_so[c];
         3'd3: return {28'b0, m_vol[c]};
         3'd6: return {31'b0, m_en[c]};
         3'd7: return {30'b0, m_pend[1], m_pend[0]};
         default: return 32'b0;
      endcase
   endfunction

   // Advances the model over one clock edge using the inputs currently driven.
   task automatic model_edge();
      int c;
      if (!rst) begin
         for (int i = 0; i < CH; i++) begin
            m_sa[i] = 0; m_so[i] = 0; m_vol[i] = 0;
            m_en[i] = 0; m_busy[i] = 0; m_pend[i] = 0; m_err[i] = 0;
         end
         e_rd = 0; e_rv = 0; e_irq = 0; e_st = 0; e_sp = 0;
         return;
      end
      e_irq = (m_pend[0] & m_en[0]) | (m_pend[1] & m_en[1]);
      e_rv = rd;
      if (rd) e_rd = m_read(addr);
      e_st = 0;
      e_sp = 0;
      c = int'(addr[3]);
      if (wr)
         case (addr[2:0])
            3'd0: begin
               if (wd[0]) m_pend[c] = 0;
               if (wd[2]) m_err[c] = 0;
            end
            3'd1: m_sa[c] = wd;
            3'd2: m_so[c] = wd;
            3'd3: m_vol[c] = wd[3:0];
            3'd4: if (!m_busy[c] && m_sa[c] < m_so[c]) e_st[c] = 1; else m_err[c] = 1;
            3'd5: if (m_busy[c]) e_sp[c] = 1;
            3'd6: m_en[c] = wd[0];
            default: ;
         endcase
      for (int i = 0; i < CH; i++) begin
         if (dn[i]) begin m_busy[i] = 0; m_pend[i] = 1; end
         if (e_sp[i]) m_busy[i] = 0;
         if (e_st[i]) m_busy[i] = 1;
      end
   endtask

   // Drives one cycle of inputs and returns shortly after the following rising edge.
   task automatic cyc(bit r_n, bit w, bit r, logic [3:0] a, logic [31:0] d, logic [1:0] done_v);
      @(negedge clk);
      rst = r_n; wr = w; rd = r; addr = a; wd = d; dn = done_v;
      model_edge();
      chk = 1;
      @(posedge clk);
      #2;
   endtask

   task automatic wr_reg(logic [3:0] a, logic [31:0] d); cyc(1, 1, 0, a, d, 0); endtask
   task automatic rd_reg(logic [3:0] a); cyc(1, 0, 1, a, 0, 0); endtask
   task automatic idle(logic [1:0] d = 0); cyc(1, 0, 0, 0, 0, d); endtask

   always @(posedge clk) begin
      #1;
      if (chk) begin
         check("readdatavalid", rvalid, e_rv);
         check("readdata", rdata, e_rd);
         check("start", st, e_st);
         check("stop", sp, e_sp);
         check("startaddr", sa, {m_sa[1], m_sa[0]});
         check("stopaddr", so, {m_so[1], m_so[0]});
         check("volume", vol, {m_vol[1], m_vol[0]});
         check("irq", irq, e_irq);
      end
   end

   initial begin
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      check("lit_reset_start", st, 2'b00);
      check("lit_reset_irq", irq, 1'b0);
      rd_reg(4'h0);
      check("lit_reset_status", rdata, 32'h0);
      check("lit_reset_rvalid", rvalid, 1'b1);
      wr_reg(4'h9, 32'h100);
      wr_reg(4'hA, 32'h200);
      wr_reg(4'hB, 32'hA);
      wr_reg(4'hC, 32'h0);
      check("lit_ch1_start", st, 2'b10);
      check("lit_ch1_startaddr", sa[63:32], 32'h100);
      check("lit_ch1_volume", vol[7:4], 4'hA);
      rd_reg(4'h8);
      check("lit_ch1_start_over", st, 2'b00);
      check("lit_ch1_busy", rdata, 32'h2);
      idle(2'b10);
      rd_reg(4'h8);
      check("lit_ch1_pending", rdata, 32'h1);
      check("lit_ch1_noirq", irq, 1'b0);
      wr_reg(4'h8, 32'h1);
      wr_reg(4'h6, 32'h1);
      wr_reg(4'h1, 32'h10);
      wr_reg(4'h2, 32'h20);
      wr_reg(4'h4, 32'h0);
      idle(2'b01);
      idle();
      check("lit_irq_set", irq, 1'b1);
      rd_reg(4'h7);
      check("lit_pending_vec", rdata, 32'h1);
      wr_reg(4'h0, 32'h1);
      check("lit_irq_lag", irq, 1'b1);
      idle();
      check("lit_irq_drop", irq, 1'b0);
      wr_reg(4'h4, 32'h0);
      idle(2'b01);
      idle();
      cyc(1, 1, 0, 4'h0, 32'h1, 2'b01);
      idle();
      idle();
      check("lit_irq_set_beats_clear", irq, 1'b1);
      wr_reg(4'h0, 32'h5);
      wr_reg(4'h1, 32'h200);
      wr_reg(4'h2, 32'h200);
      wr_reg(4'h4, 32'h0);
      check("lit_go_equal_nopulse", st, 2'b00);
      rd_reg(4'h0);
      check("lit_go_equal_err", rdata, 32'h4);
      wr_reg(4'h0, 32'h4);
      wr_reg(4'h2, 32'h300);
      wr_reg(4'h4, 32'h0);
      check("lit_go_first", st, 2'b01);
      wr_reg(4'h4, 32'h0);
      check("lit_go_second", st, 2'b00);
      rd_reg(4'h0);
      check("lit_go_twice_status", rdata, 32'h6);
      wr_reg(4'h0, 32'h4);
      wr_reg(4'h5, 32'h0);
      check("lit_halt_pulse", sp, 2'b01);
      rd_reg(4'h0);
      check("lit_halt_over", sp, 2'b00);
      check("lit_halt_status", rdata, 32'h0);
      wr_reg(4'h5, 32'h0);
      check("lit_halt_idle", sp, 2'b00);
      wr_reg(4'h4, 32'h0);
      idle(2'b01);
      wr_reg(4'h4, 32'h0);
      idle();
      check("lit_pre_reset_irq", irq, 1'b1);
      cyc(0, 0, 0, 0, 0, 0);
      check("lit_reset_nostop", sp, 2'b00);
      check("lit_reset_irq_clear", irq, 1'b0);
      rd_reg(4'h0);
      check("lit_reset_flags", rdata, 32'h0);
      for (int i = 0; i < 4000; i++) begin
         logic [3:0]  a = 4'($urandom);
         logic [31:0] d = (a[2:0] == 3'd1 || a[2:0] == 3'd2) ? $urandom_range(0, 8) : $urandom;
         logic [1:0]  dv = {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)};
         cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 4), a, d, dv);
      end
      chk = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
